// File: rtl/button_capture_if.sv
// rtl/button_capture_if.sv - board/host signal bundle for button_capture
// master: board and host side; slave: capture block side.
interface button_capture_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] button_n;
   logic [N_BTN-1:0] clr;
   logic [15:0]      status;
   logic             evt;
   logic [15:0]      cnt_word;

   modport master (output button_n, clr, input status, evt, cnt_word);
   modport slave  (input button_n, clr, output status, evt, cnt_word);
endinterface

// File: rtl/button_capture.sv
// rtl/button_capture.sv - debounced board buttons with sticky press/release flags
// Optional 4-bit press counters per button: define BUTTON_CAPTURE_COUNT_EN.
module button_capture #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 48000
) (
   input  logic            ti_clk,
   input  logic            rst_n,
   button_capture_if.slave bus
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] stab;
   logic [N_BTN-1:0] lvl;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] rel;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] fall;
   logic [CW-1:0]    db_cnt [N_BTN];
   logic             evt_q;
   logic [15:0]      status_w;

   // Inverting here makes every later stage active-high (1 = pressed).
   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ~bus.button_n;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         stab <= '0;
         for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (sync2[i] == stab[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               stab[i]   <= ~stab[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // lvl is stab one cycle late, so it doubles as the edge-detect history.
   assign rise = stab & ~lvl;
   assign fall = ~stab & lvl;

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl   <= '0;
         press <= '0;
         rel   <= '0;
         evt_q <= 1'b0;
      end else begin
         lvl   <= stab;
         press <= rise | (press & ~bus.clr);
         rel   <= fall | (rel & ~bus.clr);
         evt_q <= |(rise | fall);
      end
   end

   always_comb begin
      status_w                        = '0;
      status_w[N_BTN-1:0]             = lvl;
      status_w[2*N_BTN-1:N_BTN]       = press;
      status_w[3*N_BTN-1:2*N_BTN]     = rel;
   end

   assign bus.status = status_w;
   assign bus.evt    = evt_q;

`ifdef BUTTON_CAPTURE_COUNT_EN
   localparam int N_CNT = (N_BTN < 4) ? N_BTN : 4;

   logic [3:0]  press_cnt [N_CNT];
   logic [15:0] cnt_w;

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CNT; i++) press_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CNT; i++) begin
            if (rise[i]) press_cnt[i] <= press_cnt[i] + 4'd1;
         end
      end
   end

   always_comb begin
      cnt_w = '0;
      for (int i = 0; i < N_CNT; i++) cnt_w[4*i +: 4] = press_cnt[i];
   end

   assign bus.cnt_word = cnt_w;
`else
   assign bus.cnt_word = 16'h0000;
`endif
endmodule

// File: tb/tb_button_capture.sv
// tb/tb_button_capture.sv - scoreboard bench for button_capture
// Reference model decides stab from a window of the last D synchronized samples.
module tb_button_capture;
   localparam int N = 4;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   button_capture_if #(.N_BTN(N)) bif ();

   button_capture #(
      .N_BTN(N),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .ti_clk(clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   typedef struct {
      logic [15:0] st;
      logic        ev;
      logic [15:0] cw;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] ev_q[$];
   int          checks = 0;
   int          errors = 0;

   bit [N-1:0] m_stab, m_lvl, m_press, m_rel;
   bit [N-1:0] m_pipe[$];
   bit [N-1:0] m_hist[$];
   bit [3:0]   m_cnt[4];

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs after the next rising edge, given the inputs now applied.
   task automatic model_step();
      bit [N-1:0]  rise, fall, sync;
      bit          all_diff;
      logic [15:0] cw;
      exp_t        e;
      rise = '0;
      fall = '0;
      if (!rst_n) begin
         m_stab = '0; m_lvl = '0; m_press = '0; m_rel = '0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 4'd0;
         m_pipe.delete();
         m_pipe.push_back('0);
         m_pipe.push_back('0);
         m_hist.delete();
      end else begin
         rise    = m_stab & ~m_lvl;
         fall    = ~m_stab & m_lvl;
         m_press = rise | (m_press & ~bif.clr);
         m_rel   = fall | (m_rel & ~bif.clr);
         m_lvl   = m_stab;
         for (int i = 0; i < 4; i++) if (rise[i]) m_cnt[i] = m_cnt[i] + 4'd1;
         sync = m_pipe.pop_front();
         m_pipe.push_back(~bif.button_n);
         m_hist.push_back(sync);
         if (m_hist.size() > D) void'(m_hist.pop_front());
         if (m_hist.size() == D) begin
            for (int i = 0; i < N; i++) begin
               all_diff = 1'b1;
               foreach (m_hist[k]) if (m_hist[k][i] == m_stab[i]) all_diff = 1'b0;
               if (all_diff) m_stab[i] = ~m_stab[i];
            end
         end
      end
      cw = '0;
`ifdef BUTTON_CAPTURE_COUNT_EN
      for (int i = 0; i < 4; i++) cw[4*i +: 4] = m_cnt[i];
`endif
      e.st = {4'h0, m_rel, m_press, m_lvl};
      e.ev = |(rise | fall);
      e.cw = cw;
      exp_q.push_back(e);
      if (e.ev) ev_q.push_back(e.st);
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      bif.button_n = '1;
      bif.clr      = '0;
      rst_n        = 1'b0;
      ticks(2);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("status", bif.status, e.st);
            chk("event", {15'h0, bif.evt}, {15'h0, e.ev});
            chk("cnt_word", bif.cnt_word, e.cw);
         end
         if (bif.evt) begin
            if (ev_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL event_unexpected: got evt=1 expected none at %0t", $time);
            end else begin
               chk("event_status", bif.status, ev_q.pop_front());
            end
         end
      end
   end

   initial begin
      int p;
      rst_n        = 1'b0;
      bif.button_n = '1;
      bif.clr      = '0;
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      @(negedge clk);
      ticks(3);
      chk("reset_status", bif.status, 16'h0000);
      chk("reset_cnt", bif.cnt_word, 16'h0000);
      rst_n = 1'b1;

      // clean press of button 0: one event exactly 11 edges later
      tick();
      bif.button_n[0] = 1'b0;
      ticks(10);
      chk("press0_early_status", bif.status, 16'h0000);
      chk("press0_early_evt", {15'h0, bif.evt}, 16'h0000);
      tick();
      chk("press0_status", bif.status, 16'h0011);
      chk("press0_evt", {15'h0, bif.evt}, 16'h0001);
      tick();
      chk("press0_evt_once", {15'h0, bif.evt}, 16'h0000);

      // short glitch on button 1 is rejected
      do_reset();
      bif.button_n[1] = 1'b0;
      ticks(5);
      bif.button_n[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("glitch1_status", bif.status, 16'h0000);
         chk("glitch1_evt", {15'h0, bif.evt}, 16'h0000);
      end

      // press, release, clear of button 2
      do_reset();
      bif.button_n[2] = 1'b0;
      ticks(12);
      chk("btn2_pressed", bif.status, 16'h0044);
      bif.button_n[2] = 1'b1;
      ticks(12);
      chk("btn2_released", bif.status, 16'h0440);
      bif.clr[2] = 1'b1;
      tick();
      bif.clr = '0;
      chk("btn2_cleared", bif.status, 16'h0000);

      // clear coinciding with button 3 press flag: set wins
      do_reset();
      bif.button_n[3] = 1'b0;
      ticks(10);
      bif.clr[3] = 1'b1;
      tick();
      bif.clr = '0;
      chk("btn3_set_wins", bif.status, 16'h0088);
      tick();
      chk("btn3_flag_held", bif.status, 16'h0088);

      // reset mid-debounce discards the partial count
      do_reset();
      bif.button_n[0] = 1'b0;
      ticks(3);
      rst_n = 1'b0;
      ticks(2);
      chk("midreset_status", bif.status, 16'h0000);
      chk("midreset_evt", {15'h0, bif.evt}, 16'h0000);
      chk("midreset_cnt", bif.cnt_word, 16'h0000);
      rst_n = 1'b1;
      ticks(10);
      chk("midreset_latency_early", bif.status, 16'h0000);
      tick();
      chk("midreset_latency", bif.status, 16'h0011);

      // 17 clean presses of button 0
      do_reset();
      for (int n = 0; n < 17; n++) begin
         bif.button_n[0] = 1'b0;
         ticks(12);
         bif.button_n[0] = 1'b1;
         ticks(12);
      end
`ifdef BUTTON_CAPTURE_COUNT_EN
      chk("press_count_wrap", bif.cnt_word, 16'h0001);
`else
      chk("press_count_off", bif.cnt_word, 16'h0000);
`endif

      // randomized phase: mixed glitches, holds, clears and resets
      do_reset();
      p = 10;
      for (int t = 0; t < 3000; t++) begin
         if (t % 200 == 0) p = $urandom_range(4, 30);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, p - 1) == 0) bif.button_n[i] = ~bif.button_n[i];
            bif.clr[i] = ($urandom_range(0, 15) == 0);
         end
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            ticks($urandom_range(1, 3));
            rst_n = 1'b1;
         end
         tick();
      end
      bif.clr      = '0;
      bif.button_n = '1;
      ticks(30);

      chk("scoreboard_left", 16'(exp_q.size()), 16'h0000);
      chk("events_missed", 16'(ev_q.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_capture.md
BUTTON_CAPTURE -- requirements
Module: button_capture

Interface
REQ-001 SHALL have parameter N_BTN, default 4, meaning the number of board buttons captured; legal range 1..5.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 48000, meaning the stable-sample count required to accept a change (1 ms at 48 MHz); legal range 2..65535.
REQ-003 SHALL have port ti_clk, input, 1 bit: host-interface clock; all logic is single-clock on it.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port button_n, input, N_BTN bits: raw asynchronous board buttons, active-low (0 = pressed).
REQ-006 SHALL have port clr, input, N_BTN bits: single-cycle clear pulses, one per button, driven from a host wire/trigger.
REQ-007 SHALL have port status, output, 16 bits: wire-out word with bits [N_BTN-1:0] = debounced level (1 = pressed), [2N_BTN-1:N_BTN] = sticky press flags, [3N_BTN-1:2N_BTN] = sticky release flags, and remaining bits 0.
REQ-008 SHALL have port event, output, 1 bit: one-cycle pulse on any accepted press or release.
REQ-009 SHALL have port cnt_word, output, 16 bits: packed press counters (see Configuration).

Function
REQ-010 SHALL pass each button_n bit through a two-flop synchronizer and invert it, so that sync = 1 means pressed.
REQ-011 SHALL keep, per button, a debounced level "stab" and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 SHALL, on each cycle where sync equals stab, load the counter with 0.
REQ-013 SHALL, on each cycle where sync differs from stab and counter < DEBOUNCE_CYCLES-1, increment the counter.
REQ-014 SHALL, on each cycle where sync differs from stab and counter == DEBOUNCE_CYCLES-1, toggle stab and load the counter with 0.
REQ-015 SHALL therefore update stab exactly 2+DEBOUNCE_CYCLES cycles after a clean button_n edge, and leave stab unchanged if any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count.
REQ-016 SHALL set the press flag of a button in the cycle after stab goes 0->1, and set its release flag in the cycle after stab goes 1->0.
REQ-017 SHALL keep a set press or release flag until the clr bit of that button is 1, and the clr pulse SHALL clear both of that button's flags on the next edge.
REQ-018 SHALL, when clr and a new event for the same button occur in the same cycle, leave the flag for the new event set (set wins) and clear the other flag.
REQ-019 SHALL register status, with the debounced-level field equal to stab delayed by one cycle so that it is aligned with the flags.
REQ-020 SHALL pulse event high for exactly one cycle, aligned with the flag update, and SHALL OR simultaneous events on several buttons into that one pulse.

Reset
REQ-021 SHALL, while rst_n = 0, asynchronously force the synchronizers to 0 (released), stab = 0, counters = 0, all flags = 0, status = 16'h0000, event = 0 and cnt_word = 16'h0000.
REQ-022 SHALL, after rst_n deasserts with a button held, report a press only after 2+DEBOUNCE_CYCLES cycles, with the press flag then set.
REQ-023 SHALL, when reset is asserted mid-debounce, discard the partial count.

Configuration
REQ-024 SHALL, with macro BUTTON_CAPTURE_COUNT_EN defined, keep per button i a 4-bit press counter in cnt_word[4i+3:4i] (i < 4) that increments on each accepted press, wraps from 15 to 0, is unaffected by clr, and is registered aligned with event.
REQ-025 SHALL, without BUTTON_CAPTURE_COUNT_EN, tie cnt_word to 16'h0000 and synthesize no counter logic.

Verification (DEBOUNCE_CYCLES=8, N_BTN=4)
REQ-026 SHALL cover: button_n[0] 1->0 held -> status[0]=1, status[4]=1 and a single event pulse exactly 11 cycles after the edge.
REQ-027 SHALL cover: button_n[1] low for 5 cycles, then high -> status stays 16'h0000 and no event.
REQ-028 SHALL cover: press then release of button 2, then clr[2] pulse -> status goes 0x044 then 0x440, then 0x000 the cycle after clr.
REQ-029 SHALL cover: clr[3] in the same cycle as the button 3 press-flag set -> status[7]=1 afterwards.
REQ-030 SHALL cover: rst_n low 3 cycles into a debounce of button 0 -> all outputs 0, and the count restarts with a full 10-cycle latency from reset release.
REQ-031 SHALL cover: with BUTTON_CAPTURE_COUNT_EN, 17 clean presses of button 0 -> cnt_word = 16'h0001; without the macro -> cnt_word = 16'h0000 throughout.
